// File: rtl/ringbuffer_reader.sv
// Trigger-driven readout of a fixed window from the PMT ring buffer into a valid/ready stream.
// A 4-entry first-word-fall-through FIFO absorbs the ring buffer's 2-cycle read latency.
module ringbuffer_reader #(
  parameter int SIZE        = 12,
  parameter int WIDTH       = 14,
  parameter int PRE_SAMPLES = 16,
  parameter int WINDOW      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             wr_strobe,
  input  logic [SIZE-1:0]  waddr,
  output logic [SIZE-1:0]  rb_ain,
  output logic             rb_rd_en,
  input  logic [WIDTH-1:0] rb_dout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  output logic             trig_dropped
);
  localparam int NUMWORDS = 2 ** SIZE;
  localparam int CW       = SIZE + 3;
  localparam int LAT      = 2;
  localparam int DEPTH    = 4;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state_reg, state_next;

  logic [SIZE-1:0]  start_reg;
  logic [SIZE:0]    k_reg;
  logic [SIZE:0]    wcnt_reg;
  logic             overrun_reg;
  logic [LAT-1:0]   tag_valid_reg;
  logic [LAT-1:0]   tag_last_reg;

  logic [WIDTH:0]   fifo_mem [DEPTH];
  logic [1:0]       wr_ptr_reg;
  logic [1:0]       rd_ptr_reg;
  logic [2:0]       count_reg;

  logic [CW-1:0]    k_ext;
  logic [CW-1:0]    avail;
  logic [3:0]       occupancy;
  logic             issue;
  logic             issue_last;
  logic             push;
  logic             pop;
  logic [WIDTH:0]   head;

  // Compares run wider than k so PRE_SAMPLES + wcnt can never wrap before the test
  assign k_ext      = CW'(k_reg);
  assign avail      = CW'(PRE_SAMPLES) + CW'(wcnt_reg);
  assign occupancy  = {1'b0, count_reg} + 4'($countones(tag_valid_reg));
  assign issue      = (state_reg == READ) && (k_ext < avail) &&
                      (occupancy < 4'(DEPTH)) && (k_ext < CW'(WINDOW));
  assign issue_last = issue && (k_ext == CW'(WINDOW - 1));
  assign push       = tag_valid_reg[LAT-1];
  assign pop        = out_valid && out_ready;
  assign head       = fifo_mem[rd_ptr_reg];

  assign rb_ain       = start_reg + k_reg[SIZE-1:0];
  assign rb_rd_en     = tag_valid_reg[0];
  assign out_valid    = (count_reg != 3'd0);
  assign out_data     = out_valid ? head[WIDTH-1:0] : '0;
  assign out_last     = out_valid && head[WIDTH];
  assign busy         = (state_reg != IDLE);
  assign overrun      = overrun_reg;
  assign trig_dropped = trig && !rst && busy;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (trig) state_next = READ;
      READ:    if (issue_last) state_next = DRAIN;
      DRAIN:   if (pop && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      start_reg   <= '0;
      k_reg       <= '0;
      wcnt_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        if (trig) begin
          start_reg   <= waddr - SIZE'(PRE_SAMPLES);
          k_reg       <= '0;
          wcnt_reg    <= {{SIZE{1'b0}}, wr_strobe};
          overrun_reg <= 1'b0;
        end
      end else begin
        if (wr_strobe && (wcnt_reg != '1)) wcnt_reg <= wcnt_reg + 1'b1;
        if (issue) begin
          k_reg <= k_reg + 1'b1;
          // The writer has lapped this slot at least once since the trigger
          if (avail >= CW'(NUMWORDS) + k_ext) overrun_reg <= 1'b1;
        end
      end
    end
  end

  // Valid/last tags travel alongside each read through the buffer's latency
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_last_reg  <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[LAT-2:0], issue};
      tag_last_reg  <= {tag_last_reg[LAT-2:0], issue_last};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {tag_last_reg[LAT-1], rb_dout};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + 3'(push) - 3'(pop);
    end
  end

endmodule

// File: tb/tb_ringbuffer_reader.sv
// Randomized bench for ringbuffer_reader: a ring buffer model feeds the DUT and a window
// model (pre-trigger samples plus subsequent writes) predicts every delivered word.
module tb_ringbuffer_reader;
  localparam int SIZE   = 12;
  localparam int WIDTH  = 14;
  localparam int PRE    = 16;
  localparam int WINDOW = 64;
  localparam int N      = 2 ** SIZE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             trig = 1'b0;
  logic             wr_strobe = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [SIZE-1:0]  waddr;
  logic [SIZE-1:0]  rb_ain;
  logic             rb_rd_en;
  logic [WIDTH-1:0] rb_dout;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             overrun;
  logic             trig_dropped;

  always #5 clk = ~clk;

  ringbuffer_reader #(
    .SIZE(SIZE), .WIDTH(WIDTH), .PRE_SAMPLES(PRE), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .wr_strobe(wr_strobe), .waddr(waddr),
    .rb_ain(rb_ain), .rb_rd_en(rb_rd_en), .rb_dout(rb_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun), .trig_dropped(trig_dropped)
  );

  // Ring buffer: write port advances aout; read latches ain, then dout on rd_en
  logic [WIDTH-1:0] mem [N];
  logic [SIZE-1:0]  wptr = '0;
  logic [SIZE-1:0]  ain_q = '0;
  logic [WIDTH-1:0] dout_q = '0;
  assign waddr   = wptr;
  assign rb_dout = dout_q;
  always @(posedge clk) begin
    if (wr_strobe) begin
      mem[wptr] <= wdata;
      wptr      <= wptr + 1'b1;
    end
    ain_q  <= rb_ain;
    dout_q <= rb_rd_en ? mem[ain_q] : '0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Window model state
  logic             active = 1'b0;
  logic             seen_valid = 1'b0;
  logic             hold_pend = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;
  logic [WIDTH-1:0] exp_q [$];
  logic [SIZE-1:0]  start_addr = '0;
  int               acc_idx = 0;
  int               rd_idx = 0;
  int               trig_cyc = 0;
  int               windows_done = 0;

  task automatic monitor();
    logic act_now;
    logic [SIZE-1:0] a;
    act_now = active;
    if (rst) begin
      active    = 1'b0;
      hold_pend = 1'b0;
      exp_q.delete();
      return;
    end
    check_eq("busy", busy, act_now);
    check_eq("trig_dropped", trig_dropped, trig && act_now);
    if (!act_now) begin
      check_eq("idle_valid", out_valid, 1'b0);
      check_eq("idle_rd_en", rb_rd_en, 1'b0);
    end
    if (hold_pend) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_data", out_data, hold_data);
    end
    hold_pend = out_valid && !out_ready;
    hold_data = out_data;
    if (act_now && rb_rd_en) begin
      a = start_addr + SIZE'(rd_idx);
      check_eq("rd_addr", ain_q, a);
      check_eq("rd_written", rd_idx < exp_q.size(), 1'b1);
      rd_idx++;
    end
    if (act_now && out_valid && !seen_valid) begin
      check_eq("first_latency", cyc - trig_cyc, 4);
      seen_valid = 1'b1;
    end
    if (act_now && out_valid && out_ready) begin
      check_eq("word_written", acc_idx < exp_q.size(), 1'b1);
      if (acc_idx < exp_q.size()) check_eq("data", out_data, exp_q[acc_idx]);
      check_eq("last", out_last, acc_idx == WINDOW - 1);
      a = start_addr + SIZE'(acc_idx);
      $display("word %0d addr %0d data %h last %b", acc_idx, a, out_data, out_last);
      if (acc_idx == WINDOW - 1) begin
        check_eq("read_count", rd_idx, WINDOW);
        check_eq("overrun", overrun, 1'b0);
        active = 1'b0;
        windows_done++;
      end
      acc_idx++;
    end
    if (trig && !act_now) begin
      active     = 1'b1;
      seen_valid = 1'b0;
      trig_cyc   = cyc;
      acc_idx    = 0;
      rd_idx     = 0;
      start_addr = waddr - SIZE'(PRE);
      exp_q.delete();
      for (int j = 0; j < PRE; j++) begin
        a = start_addr + SIZE'(j);
        exp_q.push_back(mem[a]);
      end
    end
    if (active && wr_strobe && exp_q.size() < WINDOW) exp_q.push_back(wdata);
  endtask

  // One clock: observe at the falling edge, return just after the next rising edge
  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  int wr_period = 1;
  int ready_pct = 100;
  int phase = 0;

  task automatic drive_cycle();
    wr_strobe = (phase % wr_period) == 0;
    wdata     = WIDTH'($urandom);
    out_ready = $urandom_range(99) < ready_pct;
    phase++;
  endtask

  task automatic goto_waddr(input logic [SIZE-1:0] target);
    trig = 1'b0;
    out_ready = 1'b1;
    while (wptr != target) begin
      wr_strobe = 1'b1;
      wdata = WIDTH'($urandom);
      cycle();
    end
  endtask

  task automatic run_window(input int period, input int pct, input bit drop_mid,
                            input bit drop_last, input int rst_at);
    int w0;
    w0 = windows_done;
    wr_period = period;
    ready_pct = pct;
    phase = 0;
    drive_cycle();
    trig = 1'b1;
    for (int n = 1; n < 3000 && windows_done == w0; n++) begin
      cycle();
      trig = 1'b0;
      drive_cycle();
      if (n == rst_at) begin
        check_eq("rd_inflight", rb_rd_en, 1'b1);
        rst = 1'b1;
        return;
      end
      if (drop_mid && n == 10) trig = 1'b1;
      if (drop_last && out_valid && out_last && out_ready) trig = 1'b1;
    end
    check_eq("window_done", windows_done != w0, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_rb_ain", rb_ain, '0);
    check_eq("rst_rb_rd_en", rb_rd_en, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_trig_dropped", trig_dropped, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    trig = 1'b1;
    cycle();
    check_reset_outputs();
    rst = 1'b0;
    trig = 1'b0;
    cycle();

    goto_waddr(12'd100);
    run_window(1, 100, 1'b0, 1'b0, 0);

    goto_waddr(12'd5);
    run_window(1, 100, 1'b0, 1'b0, 0);

    repeat (3) cycle();
    run_window(4, 100, 1'b0, 1'b0, 0);

    repeat (3) cycle();
    run_window(1, 70, 1'b1, 1'b1, 0);

    repeat (3) cycle();
    run_window(1, 100, 1'b0, 1'b0, 8);
    cycle();
    check_reset_outputs();
    rst = 1'b0;
    trig = 1'b0;
    repeat (3) cycle();
    run_window(2, 80, 1'b0, 0, 0);

    for (int i = 0; i < 2; i++) begin
      repeat (2) cycle();
      run_window($urandom_range(1, 3), $urandom_range(50, 100), 1'b1, 1'b1, 0);
    end

    repeat (4) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
